// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage SRAM interface.
//   mem_state_e   : access FSM states (IDLE, LO half, HI half, DONE)
//   SRAM_ADDR_W   : external SRAM address width (16-bit half-word granularity)
//   SRAM_DATA_W   : external SRAM data width
//   WAIT_W        : width of the half-access wait counter (WAIT_CYCLES 1..15)
//   ADDR_BASE_DEF : default byte address of SRAM word 0
//   word_addr()   : byte address -> 17-bit 32-bit-word index (wraps modulo 2^17)
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WAIT_W      = 4;

  localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Underflow below the base is intentional: the subtraction wraps and the
  // truncation keeps the low 17 word-index bits.
  function automatic logic [SRAM_ADDR_W-2:0] word_addr(input logic [31:0] byte_addr,
                                                       input logic [31:0] base);
    return (SRAM_ADDR_W-1)'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// ---------------------------------------------------------------------------
// mem_wait_cnt
// Loadable down-counter timing one SRAM half-access.
//   clk        : clock
//   rst        : synchronous active-low reset (counter cleared to 0)
//   load_i     : load load_val_i (takes priority over counting)
//   en_i       : half-access in progress, count down
//   load_val_i : cycles per half-access
//   done_o     : high during the final cycle of the half-access
// ---------------------------------------------------------------------------
module mem_wait_cnt
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              done_o
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter holds the number of cycles left including the current one,
  // so the last cycle is the one where it reads 1.
  assign done_o = en_i && (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/mem_sram_stage.sv
// ---------------------------------------------------------------------------
// mem_sram_stage
// MEM pipeline stage driving a 16-bit asynchronous SRAM. A 32-bit access is
// split into a LO half (sram_addr = {w,0}) and a HI half (sram_addr = {w,1}),
// each lasting WAIT_CYCLES clocks. While an access is in flight ready is low
// and upstream must hold its inputs.
//
// Parameters
//   WAIT_CYCLES : cycles per SRAM half-access (1..15)
//   ADDR_BASE   : byte address subtracted from alu_result_in before translation
//
// Ports
//   clk, rst              : clock, synchronous active-low reset
//   wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, st_val_in, dest_in
//                         : EXE/MEM request
//   ready                 : 0 = freeze upstream pipeline registers
//   wb_en, mem_r_en, alu_result, mem_data, dest
//                         : MEM/WB pipeline register outputs
//   sram_addr, sram_dq_in, sram_dq_out, sram_dq_oe, sram_we_n
//                         : SRAM pins (dq split into in/out/output-enable)
//
// Build option
//   MEM_RDBUF_EN : adds a one-entry read buffer; a read hitting it completes
//                  from IDLE in one cycle without touching the SRAM.
// ---------------------------------------------------------------------------
module mem_sram_stage
  import mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [31:0]            alu_result_in,
  input  logic [31:0]            st_val_in,
  input  logic [3:0]             dest_in,
  output logic                   ready,
  output logic                   wb_en,
  output logic                   mem_r_en,
  output logic [31:0]            alu_result,
  output logic [31:0]            mem_data,
  output logic [3:0]             dest,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  mem_state_e state_q;

  logic                   wb_en_q;
  logic                   mem_r_en_q;
  logic [31:0]            alu_result_q;
  logic [31:0]            mem_data_q;
  logic [3:0]             dest_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [SRAM_DATA_W-1:0] sram_dq_out_q;
  logic                   sram_dq_oe_q;
  logic                   sram_we_n_q;
  logic [SRAM_DATA_W-1:0] rd_lo_q;
  logic [SRAM_DATA_W-1:0] rd_hi_q;

  logic                   req;
  logic                   is_wr;
  logic                   is_rd;
  logic [SRAM_ADDR_W-2:0] w;
  logic                   start;
  logic                   cnt_load;
  logic                   cnt_en;
  logic                   cnt_done;
  logic                   rd_hit;
  logic [31:0]            rd_hit_data;
  logic                   ready_d;

  // Read and write both asserted is treated as a write.
  assign req   = mem_r_en_in | mem_w_en_in;
  assign is_wr = mem_w_en_in;
  assign is_rd = mem_r_en_in & ~mem_w_en_in;
  assign w     = word_addr(alu_result_in, ADDR_BASE);

  assign start    = (state_q == ST_IDLE) && req && !rd_hit;
  assign cnt_load = start || ((state_q == ST_LO) && cnt_done);
  assign cnt_en   = (state_q == ST_LO) || (state_q == ST_HI);

  mem_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (WAIT_W'(WAIT_CYCLES)),
    .done_o     (cnt_done)
  );

`ifdef MEM_RDBUF_EN
  logic                   buf_valid_q;
  logic [SRAM_ADDR_W-2:0] buf_tag_q;
  logic [31:0]            buf_data_q;

  assign rd_hit      = (state_q == ST_IDLE) && is_rd && buf_valid_q && (buf_tag_q == w);
  assign rd_hit_data = buf_data_q;

  // Filled by every completed SRAM read; a write to the buffered word keeps
  // the copy coherent instead of invalidating it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (state_q == ST_DONE) begin
      if (is_rd) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= w;
        buf_data_q  <= {rd_hi_q, rd_lo_q};
      end else if (is_wr && buf_valid_q && (buf_tag_q == w)) begin
        buf_data_q <= st_val_in;
      end
    end
  end
`else
  assign rd_hit      = 1'b0;
  assign rd_hit_data = '0;
`endif

  // ready is combinational so a stalled request is frozen in the same cycle.
  always_comb begin
    ready_d = 1'b0;
    if (rst) begin
      ready_d = ((state_q == ST_IDLE) && (!req || rd_hit)) || (state_q == ST_DONE);
    end
  end

  assign ready = ready_d;

  // Access FSM with registered SRAM pins; the MEM/WB register loads on every
  // edge that ends a ready cycle. Reset abandons any access and releases the
  // bus immediately, so a half-written word is left as is.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      rd_lo_q       <= '0;
      rd_hi_q       <= '0;
      wb_en_q       <= 1'b0;
      mem_r_en_q    <= 1'b0;
      alu_result_q  <= '0;
      mem_data_q    <= '0;
      dest_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_LO;
            sram_addr_q   <= {w, 1'b0};
            sram_dq_out_q <= st_val_in[15:0];
            sram_dq_oe_q  <= is_wr;
            sram_we_n_q   <= ~is_wr;
          end
        end
        ST_LO: begin
          if (cnt_done) begin
            if (is_rd) begin
              rd_lo_q <= sram_dq_in;
            end
            state_q       <= ST_HI;
            sram_addr_q   <= {w, 1'b1};
            sram_dq_out_q <= st_val_in[31:16];
          end
        end
        ST_HI: begin
          if (cnt_done) begin
            if (is_rd) begin
              rd_hi_q <= sram_dq_in;
            end
            state_q      <= ST_DONE;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (ready_d) begin
        wb_en_q      <= wb_en_in;
        mem_r_en_q   <= mem_r_en_in;
        alu_result_q <= alu_result_in;
        dest_q       <= dest_in;
        // mem_data only changes when a read completes; writes and ALU ops
        // leave the previous load value in place.
        if ((state_q == ST_DONE) && is_rd) begin
          mem_data_q <= {rd_hi_q, rd_lo_q};
        end else if (rd_hit) begin
          mem_data_q <= rd_hit_data;
        end
      end
    end
  end

  assign wb_en       = wb_en_q;
  assign mem_r_en    = mem_r_en_q;
  assign alu_result  = alu_result_q;
  assign mem_data    = mem_data_q;
  assign dest        = dest_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_mem_sram_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_sram_stage
// Directed bench for mem_sram_stage with WAIT_CYCLES=2, ADDR_BASE=1024 and a
// simple 16-bit SRAM array attached to the SRAM pins. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_sram_stage;

  logic        clk;
  logic        rst;
  logic        wbEnIn;
  logic        memREnIn;
  logic        memWEnIn;
  logic [31:0] aluResultIn;
  logic [31:0] stValIn;
  logic [3:0]  destIn;
  logic        ready;
  logic        wbEn;
  logic        memREn;
  logic [31:0] aluResult;
  logic [31:0] memData;
  logic [3:0]  dest;
  logic [17:0] sramAddr;
  logic [15:0] sramDqIn;
  logic [15:0] sramDqOut;
  logic        sramDqOe;
  logic        sramWeN;

  int total;
  int bad;

  logic [15:0] sramMem [0:262143];

  mem_sram_stage #(
    .WAIT_CYCLES (2),
    .ADDR_BASE   (32'd1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_en_in      (wbEnIn),
    .mem_r_en_in   (memREnIn),
    .mem_w_en_in   (memWEnIn),
    .alu_result_in (aluResultIn),
    .st_val_in     (stValIn),
    .dest_in       (destIn),
    .ready         (ready),
    .wb_en         (wbEn),
    .mem_r_en      (memREn),
    .alu_result    (aluResult),
    .mem_data      (memData),
    .dest          (dest),
    .sram_addr     (sramAddr),
    .sram_dq_in    (sramDqIn),
    .sram_dq_out   (sramDqOut),
    .sram_dq_oe    (sramDqOe),
    .sram_we_n     (sramWeN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM modelled as a write on each clock while we_n is low.
  always @(posedge clk) begin
    if (!sramWeN) begin
      sramMem[sramAddr] <= sramDqOut;
    end
  end

  assign sramDqIn = sramMem[sramAddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wb, input logic rd, input logic wr,
                               input logic [31:0] alu, input logic [31:0] st,
                               input logic [3:0] dst);
    wbEnIn      = wb;
    memREnIn    = rd;
    memWEnIn    = wr;
    aluResultIn = alu;
    stValIn     = st;
    destIn      = dst;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 262144; i++) sramMem[i] = 16'h0000;

    // Reset
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    checkOutput("rst_ready", {31'b0, ready}, 32'h0);
    checkOutput("rst_wb_en", {31'b0, wbEn}, 32'h0);
    checkOutput("rst_alu_result", aluResult, 32'h0);
    checkOutput("rst_mem_data", memData, 32'h0);
    checkOutput("rst_we_n", {31'b0, sramWeN}, 32'h1);
    checkOutput("rst_dq_oe", {31'b0, sramDqOe}, 32'h0);
    rst = 1'b1;
    tick();

    // Non-memory op
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd5);
    checkOutput("alu_ready", {31'b0, ready}, 32'h1);
    tick();
    checkOutput("alu_result", aluResult, 32'h1234);
    checkOutput("alu_dest", {28'b0, dest}, 32'd5);
    checkOutput("alu_wb_en", {31'b0, wbEn}, 32'h1);
    checkOutput("alu_we_n", {31'b0, sramWeN}, 32'h1);

    // Write 0xDEADBEEF to 1024
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'd0);
    checkOutput("wr_c1_ready", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("wr_c2_addr", {14'b0, sramAddr}, 32'h0);
    checkOutput("wr_c2_dq", {16'b0, sramDqOut}, 32'hBEEF);
    checkOutput("wr_c2_we_n", {31'b0, sramWeN}, 32'h0);
    checkOutput("wr_c2_oe", {31'b0, sramDqOe}, 32'h1);
    checkOutput("wr_c2_ready", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("wr_c3_addr", {14'b0, sramAddr}, 32'h0);
    checkOutput("wr_c3_dq", {16'b0, sramDqOut}, 32'hBEEF);
    tick();
    checkOutput("wr_c4_addr", {14'b0, sramAddr}, 32'h1);
    checkOutput("wr_c4_dq", {16'b0, sramDqOut}, 32'hDEAD);
    checkOutput("wr_c4_we_n", {31'b0, sramWeN}, 32'h0);
    tick();
    checkOutput("wr_c5_addr", {14'b0, sramAddr}, 32'h1);
    checkOutput("wr_c5_ready", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("wr_c6_ready", {31'b0, ready}, 32'h1);
    checkOutput("wr_c6_we_n", {31'b0, sramWeN}, 32'h1);
    checkOutput("wr_c6_oe", {31'b0, sramDqOe}, 32'h0);
    tick();
    checkOutput("wr_alu_result", aluResult, 32'd1024);
    checkOutput("wr_mem_r_en", {31'b0, memREn}, 32'h0);

    // Read back 1024
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd3);
    checkOutput("rd_c1_ready", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("rd_c2_addr", {14'b0, sramAddr}, 32'h0);
    checkOutput("rd_c2_we_n", {31'b0, sramWeN}, 32'h1);
    checkOutput("rd_c2_oe", {31'b0, sramDqOe}, 32'h0);
    tick();
    tick();
    checkOutput("rd_c4_addr", {14'b0, sramAddr}, 32'h1);
    tick();
    tick();
    checkOutput("rd_c6_ready", {31'b0, ready}, 32'h1);
    tick();
    checkOutput("rd_mem_data", memData, 32'hDEADBEEF);
    checkOutput("rd_mem_r_en", {31'b0, memREn}, 32'h1);
    checkOutput("rd_dest", {28'b0, dest}, 32'd3);

    // Second read of 1024
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd7);
`ifdef MEM_RDBUF_EN
    checkOutput("rd2_hit_ready", {31'b0, ready}, 32'h1);
    tick();
    checkOutput("rd2_hit_we_n", {31'b0, sramWeN}, 32'h1);
`else
    checkOutput("rd2_c1_ready", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("rd2_c2_addr", {14'b0, sramAddr}, 32'h0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("rd2_c6_ready", {31'b0, ready}, 32'h1);
    tick();
`endif
    checkOutput("rd2_mem_data", memData, 32'hDEADBEEF);
    checkOutput("rd2_dest", {28'b0, dest}, 32'd7);

    // Read and write both high: write to 1028 (word 1), mem_data unchanged
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 4'd2);
    checkOutput("rw_c1_ready", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("rw_c2_addr", {14'b0, sramAddr}, 32'h2);
    checkOutput("rw_c2_dq", {16'b0, sramDqOut}, 32'hF00D);
    checkOutput("rw_c2_we_n", {31'b0, sramWeN}, 32'h0);
    tick();
    tick();
    checkOutput("rw_c4_addr", {14'b0, sramAddr}, 32'h3);
    checkOutput("rw_c4_dq", {16'b0, sramDqOut}, 32'hCAFE);
    tick();
    tick();
    checkOutput("rw_c6_ready", {31'b0, ready}, 32'h1);
    tick();
    checkOutput("rw_mem_data", memData, 32'hDEADBEEF);
    checkOutput("rw_mem_r_en", {31'b0, memREn}, 32'h1);
    checkOutput("rw_sram_word", {sramMem[3], sramMem[2]}, 32'hCAFEF00D);

    // Underflow read of 1020 wraps to word 0x1FFFF
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1020, 32'h0, 4'd1);
    tick();
    checkOutput("uf_lo_addr", {14'b0, sramAddr}, 32'h3FFFE);
    tick();
    tick();
    checkOutput("uf_hi_addr", {14'b0, sramAddr}, 32'h3FFFF);
    tick();
    tick();
    checkOutput("uf_c6_ready", {31'b0, ready}, 32'h1);
    tick();
    checkOutput("uf_alu_result", aluResult, 32'd1020);

    // Reset during HI of a write
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd1032, 32'h11112222, 4'd4);
    tick();
    tick();
    tick();
    checkOutput("rsthi_addr", {14'b0, sramAddr}, 32'h5);
    checkOutput("rsthi_we_n_before", {31'b0, sramWeN}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rsthi_ready_low", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("rsthi_we_n", {31'b0, sramWeN}, 32'h1);
    checkOutput("rsthi_oe", {31'b0, sramDqOe}, 32'h0);
    checkOutput("rsthi_wb_en", {31'b0, wbEn}, 32'h0);
    checkOutput("rsthi_mem_r_en", {31'b0, memREn}, 32'h0);
    checkOutput("rsthi_alu_result", aluResult, 32'h0);
    checkOutput("rsthi_mem_data", memData, 32'h0);
    checkOutput("rsthi_dest", {28'b0, dest}, 32'h0);
    checkOutput("rsthi_ready", {31'b0, ready}, 32'h0);
    tick();
    checkOutput("rsthi_ready2", {31'b0, ready}, 32'h0);
    checkOutput("rsthi_we_n2", {31'b0, sramWeN}, 32'h1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    checkOutput("rsthi_ready_after", {31'b0, ready}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sram_stage.md
MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, cycles per SRAM half-access (legal 1..15).
REQ-002 SHALL have parameter ADDR_BASE, default 1024, byte address subtracted from alu_result before translation.
REQ-003 SHALL have ports clk in 1 (clock), rst in 1 (reset; one clock, reset synchronous and active-low).
REQ-004 SHALL have ports wb_en_in, mem_r_en_in, mem_w_en_in in 1 each (EXE/MEM control).
REQ-005 SHALL have ports alu_result_in in 32 (byte address or ALU value), st_val_in in 32 (store data), dest_in in 4 (dest register).
REQ-006 SHALL have port ready out 1 (0 = freeze all upstream pipeline registers).
REQ-007 SHALL have MEM/WB outputs wb_en, mem_r_en out 1; alu_result, mem_data out 32; dest out 4.
REQ-008 SHALL have SRAM ports sram_addr out 18, sram_dq_in in 16, sram_dq_out out 16, sram_dq_oe out 1, sram_we_n out 1.

Function
REQ-009 SHALL implement FSM IDLE, LO, HI, DONE; IDLE->LO when mem_r_en_in|mem_w_en_in, LO->HI and HI->DONE after WAIT_CYCLES cycles each, DONE->IDLE unconditionally.
REQ-010 SHALL drive ready=1 in IDLE with no request and in DONE, else 0.
REQ-011 SHALL capture all MEM/WB outputs at the clock edge ending any cycle with ready=1 (non-memory op latency 1; memory op latency 2*WAIT_CYCLES+2).
REQ-012 SHALL form word address w = (alu_result_in - ADDR_BASE)>>2, truncated to 17 bits (wrap modulo 2^17 words, including underflow), and drive sram_addr = {w, 0} in LO and {w, 1} in HI.
REQ-013 SHALL, on read, latch sram_dq_in into mem_data[15:0] on the last LO cycle and mem_data[31:16] on the last HI cycle.
REQ-014 SHALL, on write, drive sram_we_n=0, sram_dq_oe=1 throughout LO (st_val_in[15:0]) and HI (st_val_in[31:16]); otherwise sram_we_n=1, sram_dq_oe=0.
REQ-015 SHALL treat mem_r_en_in and mem_w_en_in both high as a write; mem_data then holds its prior value.
REQ-016 SHALL rely on upstream holding all inputs stable while ready=0; inputs sampled in LO/HI are those of the accepted request.
REQ-017 SHALL pass wb_en_in, mem_r_en_in, alu_result_in, dest_in through unchanged to MEM/WB outputs.

Reset
REQ-018 SHALL, while rst=0 at a clock edge, force state IDLE, wait counter 0, all MEM/WB outputs 0, sram_we_n=1, sram_dq_oe=0.
REQ-019 SHALL drive ready=0 combinationally while rst=0.
REQ-020 SHALL abort any in-flight access on reset with no further SRAM writes; partial SRAM contents are not restored.

Configuration
REQ-021 SHALL honour macro MEM_RDBUF_EN: when defined, include a one-entry read buffer (valid, 17-bit tag, 32-bit data).
REQ-022 SHALL, with MEM_RDBUF_EN, complete a read hit (valid and tag==w) in IDLE with ready=1 and mem_data from the buffer (latency 1, no SRAM cycle); fill on read completion; update data on write to the same w; clear valid on reset.
REQ-023 SHALL, without MEM_RDBUF_EN, contain no buffer logic, and every read SHALL take the full FSM path.

Structure
REQ-024 SHALL place the state enum, SRAM_ADDR_W=18, SRAM_DATA_W=16 and default ADDR_BASE in shared package mem_pkg.
REQ-025 SHALL use one sub-module, mem_wait_cnt (loadable down-counter, done pulse on final cycle), for half-access timing.

Verification
REQ-026 Non-memory op alu_result_in=0x1234, wb_en_in=1, dest_in=5 -> ready=1, next edge alu_result=0x1234, dest=5, sram_we_n stays 1.
REQ-027 Write 0xDEADBEEF to 1024, WAIT_CYCLES=2 -> sram_addr 0 with dq_out 0xBEEF for 2 cycles, then 1 with 0xDEAD for 2 cycles, ready=0 for 5 cycles, 1 in cycle 6.
REQ-028 Read back 1024 -> mem_data=0xDEADBEEF after 6 cycles; with MEM_RDBUF_EN a second read of 1024 -> ready=1 immediately, same data.
REQ-029 Read address 1020 (underflow) -> sram_addr={17'h1FFFF,0} then {17'h1FFFF,1}.
REQ-030 rst=0 during HI of a write -> next edge state IDLE, sram_we_n=1, all MEM/WB outputs 0, ready=0 until rst=1.
REQ-031 mem_r_en_in=mem_w_en_in=1 -> write sequence performed, mem_data unchanged.
